// File: rtl/div4_pkg.sv
// Shared types and constants for the 4-bit sequential divider.
// Both the controller and the bench import this package.
package div4_pkg;

  localparam int DIV_W     = 4;
  localparam int DIV_STEPS = 4;

  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub4_borrow.sv
// Combinational 4-bit ripple subtractor: d = a - b mod 16, borrow = (a < b).
// Built as a + ~b + 1 through four full-adder stages; borrow is the inverted carry out.
module sub4_borrow (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] d,
  output logic       borrow
);

  logic [4:0] c;
  logic [3:0] nb;

  assign nb   = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign d[i]   = a[i] ^ nb[i] ^ c[i];
    assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
  end

  assign borrow = ~c[4];

endmodule

// File: rtl/seq_divider4.sv
// Restoring 4-bit unsigned divider, one quotient bit per clock through a single
// shared subtractor. Handshake: start sampled only in IDLE; busy high in CALC; done one-cycle pulse.
import div4_pkg::*;

module seq_divider4 (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             dbz,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [1:0]       cnt_q;
  logic [DIV_W-1:0] r_q;
  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] dvs_q;
  logic [DIV_W-1:0] q_sr;

  logic [DIV_W:0]   shifted;
  logic [DIV_W-1:0] diff;
  logic             borrow;
  logic             accept;
  logic [DIV_W-1:0] r_next;

  // Bit 4 of the shifted remainder set means shifted >= 16 > divisor, so the subtract always fits.
  assign shifted = {r_q, dvd_q[cnt_q]};
  assign accept  = shifted[DIV_W] | ~borrow;
  assign r_next  = accept ? diff : shifted[DIV_W-1:0];

  sub4_borrow u_sub (
    .a      (shifted[DIV_W-1:0]),
    .b      (dvs_q),
    .d      (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor == '0) ? DONE : CALC;
      CALC:    if (cnt_q == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      r_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      q_sr      <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= DBZ_QUOTIENT;
              remainder <= dividend;
              dbz       <= 1'b1;
            end else begin
              dvd_q <= dividend;
              dvs_q <= divisor;
              r_q   <= '0;
              q_sr  <= '0;
              dbz   <= 1'b0;
              cnt_q <= 2'(DIV_STEPS - 1);
            end
          end
        end
        CALC: begin
          r_q  <= r_next;
          q_sr <= {q_sr[DIV_W-2:0], accept};
          if (cnt_q == 2'd0) begin
            quotient  <= {q_sr[DIV_W-2:0], accept};
            remainder <= r_next;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Both flags decode the state register only, so neither has a path from start.
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4: directed cases plus a shuffled sweep of
// all 256 operand pairs against a plain-arithmetic reference model.
import div4_pkg::*;

module tb_seq_divider4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected {quotient, remainder, dbz} per issued division.
  logic [8:0] exp_q[$];

  seq_divider4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer division, with the divide-by-zero convention.
  function automatic logic [8:0] ref_div(input logic [3:0] a, input logic [3:0] b);
    int q, r;
    if (b == 0) return {4'hF, a, 1'b1};
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return {q[3:0], r[3:0], 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division from IDLE, wait for done, check results and timing,
  // and return with the DUT back in IDLE.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b);
    logic [8:0] e;
    int busy_cnt, lat, exp_lat, exp_busy;
    bit got;
    busy_cnt = 0;
    lat      = 0;
    got      = 0;
    exp_lat  = (b == 0) ? 1 : 5;
    exp_busy = (b == 0) ? 0 : 4;
    exp_q.push_back(ref_div(a, b));
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int c = 1; c <= 10 && !got; c++) begin
      tick();
      start = 1'b0;
      if (busy && done) check("busy_done_overlap", 32'(busy & done), 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        got = 1;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      check("done_timeout", 32'(got), 32'd1);
    end else begin
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_busy);
      check("quotient", 32'(quotient), 32'(e[8:5]));
      check("remainder", 32'(remainder), 32'(e[4:1]));
      check("dbz", 32'(dbz), 32'(e[0]));
      if (b != 0) begin
        check("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        check("rem_lt_div", 32'(remainder < b), 32'd1);
      end
    end
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pairs[256];
    int done_cnt;
    logic [8:0] e;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    run_div(4'd13, 4'd3);
    run_div(4'd15, 4'd1);
    run_div(4'd2, 4'd7);
    run_div(4'd15, 4'd9);
    run_div(4'd9, 4'd0);
    run_div(4'd0, 4'd5);
    run_div(4'd15, 4'd15);

    // Starts during CALC and DONE must be dropped.
    e        = ref_div(4'd12, 4'd5);
    done_cnt = 0;
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      if (done) done_cnt++;
      if (c == 2 || done) begin
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
      end
    end
    check("ignored_start_done_pulses", done_cnt, 1);
    check("ignored_start_quotient", 32'(quotient), 32'(e[8:5]));
    check("ignored_start_remainder", 32'(remainder), 32'(e[4:1]));
    check("ignored_start_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("held_quotient", 32'(quotient), 32'(e[8:5]));
    check("held_remainder", 32'(remainder), 32'(e[4:1]));

    // Asynchronous reset in the middle of a division.
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    tick();
    start = 1'b0;
    tick();
    check("mid_calc_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_quotient", 32'(quotient), 32'd0);
    check("async_rst_remainder", 32'(remainder), 32'd0);
    check("async_rst_dbz", 32'(dbz), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    tick();
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("no_activity_after_rst", done_cnt, 0);
    run_div(4'd14, 4'd3);

    // Every operand pair, in shuffled order.
    for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j        = $urandom_range(i, 0);
      t        = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = t;
    end
    for (int i = 0; i < 256; i++) run_div(pairs[i][7:4], pairs[i][3:0]);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
